// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage ALU-control decode, 32-bit ALU and branch-target adder
//   with the EX/MEM-side output register.
// Optional feature: define ALU_SHIFT_EN to decode sll/srl (funct 000000/000010).
// Ports:
//   clock         pipeline clock; registers update on the falling edge
//   reset         synchronous active-high clear (wins over clkEnable)
//   clkEnable     stall/step enable; registers hold when low
//   PCSrc         branch-taken flush; clears registers when enabled
//   inPC          PC+1 of the instruction in EX
//   data1, data2  final ALU operands
//   signExtend    immediate: [5:0] funct, [10:6] shamt, [9:0] branch offset
//   aluOp         main-control ALU opcode
//   operation     combinational decoded ALU operation
//   aluResult     registered ALU result
//   zero          registered (ALU result == 0)
//   outPC         registered branch target
//   outCurrentPC  registered copy of inPC
module ex_alu_unit #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clkEnable,
    input  logic              PCSrc,
    input  logic [PC_W-1:0]   inPC,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] signExtend,
    input  logic [1:0]        aluOp,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] aluResult,
    output logic              zero,
    output logic [PC_W-1:0]   outPC,
    output logic [PC_W-1:0]   outCurrentPC
);
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   target;

    assign funct = signExtend[5:0];
    assign shamt = signExtend[10:6];
    // Word-addressed PC: offset added unshifted, wraps modulo 2^PC_W.
    assign target = inPC + signExtend[PC_W-1:0];

    always_comb begin
        operation = 4'b1111;
        case (aluOp)
            2'b00: operation = 4'b0010;
            2'b01: operation = 4'b0110;
            2'b11: operation = 4'b0001;
            default:
                case (funct)
                    6'b100000: operation = 4'b0010;
                    6'b100010: operation = 4'b0110;
                    6'b100100: operation = 4'b0000;
                    6'b100101: operation = 4'b0001;
                    6'b101010: operation = 4'b0111;
                    6'b100111: operation = 4'b1100;
`ifdef ALU_SHIFT_EN
                    6'b000000: operation = 4'b1000;
                    6'b000010: operation = 4'b1001;
`endif
                    default:   operation = 4'b1111;
                endcase
        endcase
    end

    always_comb begin
        result = '0;
        case (operation)
            4'b0010: result = data1 + data2;
            4'b0110: result = data1 - data2;
            4'b0000: result = data1 & data2;
            4'b0001: result = data1 | data2;
            4'b0111: result = {{(DATA_W-1){1'b0}}, $signed(data1) < $signed(data2)};
            4'b1100: result = ~(data1 | data2);
`ifdef ALU_SHIFT_EN
            4'b1000: result = data2 << shamt;
            4'b1001: result = data2 >> shamt;
`endif
            default: result = '0;
        endcase
    end

    // Flush only takes effect on an enabled edge; a stalled flush is dropped.
    always_ff @(negedge clock) begin
        if (reset || (clkEnable && PCSrc)) begin
            aluResult    <= '0;
            zero         <= 1'b0;
            outPC        <= '0;
            outCurrentPC <= '0;
        end else if (clkEnable) begin
            aluResult    <= result;
            zero         <= (result == '0);
            outPC        <= target;
            outCurrentPC <= inPC;
        end
    end
endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: scoreboard bench for ex_alu_unit (falling-edge registers)
module tb_ex_alu_unit;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic [9:0]  pc;
        logic [9:0]  cur;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        fl;
        logic [9:0]  pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [1:0]  op;
        logic [3:0]  opx;
        exp_t        e;
    } stim_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clkEnable = 1'b0;
    logic        PCSrc = 1'b0;
    logic [9:0]  inPC = '0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic [31:0] signExtend = '0;
    logic [1:0]  aluOp = '0;
    logic [3:0]  operation;
    logic [31:0] aluResult;
    logic        zero;
    logic [9:0]  outPC;
    logic [9:0]  outCurrentPC;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    ex_alu_unit dut (
        .clock(clock), .reset(reset), .clkEnable(clkEnable), .PCSrc(PCSrc),
        .inPC(inPC), .data1(data1), .data2(data2), .signExtend(signExtend),
        .aluOp(aluOp), .operation(operation), .aluResult(aluResult), .zero(zero),
        .outPC(outPC), .outCurrentPC(outCurrentPC)
    );

    always #5 clock = ~clock;

    function automatic stim_t mk(input logic rst, en, fl, input logic [9:0] pc,
                                 input logic [31:0] a, b, s, input logic [1:0] op,
                                 input logic [3:0] opx, input logic [31:0] r,
                                 input logic z, input logic [9:0] tpc, cur);
        stim_t t;
        t.rst = rst; t.en = en; t.fl = fl; t.pc = pc; t.a = a; t.b = b; t.s = s;
        t.op = op; t.opx = opx; t.e.r = r; t.e.z = z; t.e.pc = tpc; t.e.cur = cur;
        return t;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, b, s,
                                   input logic [9:0] pc);
        exp_t e;
        logic [31:0] r;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b11: r = a | b;
            default:
                case (s[5:0])
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h27: r = ~(a | b);
`ifdef ALU_SHIFT_EN
                    6'h00: r = b << s[10:6];
                    6'h02: r = b >> s[10:6];
`endif
                    default: r = 32'd0;
                endcase
        endcase
        e.r = r; e.z = (r == 32'd0); e.pc = pc + s[9:0]; e.cur = pc;
        return e;
    endfunction

    // Drives one transaction just after a rising edge, records its expectation,
    // lets the falling edge capture it and returns on the next rising edge + 1.
    task automatic apply(input stim_t t);
        reset = t.rst; clkEnable = t.en; PCSrc = t.fl; inPC = t.pc;
        data1 = t.a; data2 = t.b; signExtend = t.s; aluOp = t.op;
        q.push_back(t.e);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic run_rows(input string name, input stim_t rows[$]);
        exp_t e;
        foreach (rows[i]) begin
            apply(rows[i]);
            tests++;
            if (operation !== rows[i].opx) begin
                fails++;
                $display("FAIL %s[%0d] operation: got %b expected %b", name, i, operation, rows[i].opx);
            end
            e = q.pop_front();
            tests++;
            if ({aluResult, zero, outPC, outCurrentPC} !== e) begin
                fails++;
                $display("FAIL %s[%0d] outputs: got r=%h z=%b pc=%0d cur=%0d expected r=%h z=%b pc=%0d cur=%0d",
                         name, i, aluResult, zero, outPC, outCurrentPC, e.r, e.z, e.pc, e.cur);
            end
        end
    endtask

    task automatic test_reset();
        stim_t rows[$];
        rows.push_back(mk(1, 0, 0, 10'd9, 32'd3, 32'd4, 32'd0, 2'b00, 4'b0010, 32'd0, 1'b0, 10'd0, 10'd0));
        run_rows("reset", rows);
    endtask

    task automatic test_rtype();
        stim_t rows[$];
        rows.push_back(mk(0, 1, 0, 10'd100, 32'd5, 32'd5, 32'h22, 2'b10, 4'b0110, 32'd0, 1'b1, 10'd134, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd100, 32'hFFFFFFFF, 32'd1, 32'h2A, 2'b10, 4'b0111, 32'd1, 1'b0, 10'd142, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd100, 32'd0, 32'd0, 32'h27, 2'b10, 4'b1100, 32'hFFFFFFFF, 1'b0, 10'd139, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd100, 32'hF0F0, 32'hFF00, 32'h24, 2'b10, 4'b0000, 32'hF000, 1'b0, 10'd136, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd100, 32'h1, 32'h6, 32'h25, 2'b10, 4'b0001, 32'h7, 1'b0, 10'd137, 10'd100));
        run_rows("rtype", rows);
    endtask

    task automatic test_add_wrap();
        stim_t rows[$];
        rows.push_back(mk(0, 1, 0, 10'd100, 32'hFFFFFFFF, 32'd2, 32'd0, 2'b00, 4'b0010, 32'd1, 1'b0, 10'd100, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd100, 32'd7, 32'd9, 32'h3F, 2'b10, 4'b1111, 32'd0, 1'b1, 10'd163, 10'd100));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'd1, 32'd0, 2'b01, 4'b0110, 32'hFFFFFFFF, 1'b0, 10'd0, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'h10, 32'h3, 32'd0, 2'b11, 4'b0001, 32'h13, 1'b0, 10'd0, 10'd0));
        run_rows("add_wrap", rows);
    endtask

    task automatic test_branch();
        stim_t rows[$];
        rows.push_back(mk(0, 1, 0, 10'd1020, 32'd0, 32'd0, 32'd6, 2'b00, 4'b0010, 32'd0, 1'b1, 10'd2, 10'd1020));
        rows.push_back(mk(0, 1, 0, 10'd5, 32'd0, 32'd0, 32'hFFFFFFFE, 2'b00, 4'b0010, 32'd0, 1'b1, 10'd3, 10'd5));
        run_rows("branch", rows);
    endtask

    task automatic test_stall_flush();
        stim_t rows[$];
        rows.push_back(mk(0, 1, 0, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd5, 1'b0, 10'd7, 10'd7));
        rows.push_back(mk(0, 0, 0, 10'd50, 32'd1, 32'd1, 32'd0, 2'b01, 4'b0110, 32'd5, 1'b0, 10'd7, 10'd7));
        rows.push_back(mk(0, 1, 1, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd0, 1'b0, 10'd0, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd5, 1'b0, 10'd7, 10'd7));
        rows.push_back(mk(0, 0, 1, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd5, 1'b0, 10'd7, 10'd7));
        rows.push_back(mk(1, 1, 1, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd0, 1'b0, 10'd0, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd5, 1'b0, 10'd7, 10'd7));
        rows.push_back(mk(1, 0, 0, 10'd7, 32'd9, 32'd4, 32'd0, 2'b01, 4'b0110, 32'd0, 1'b0, 10'd0, 10'd0));
        run_rows("stall_flush", rows);
    endtask

    task automatic test_shift();
        stim_t rows[$];
`ifdef ALU_SHIFT_EN
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'd1, 32'h100, 2'b10, 4'b1000, 32'd16, 1'b0, 10'd256, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'h80000000, 32'h7C2, 2'b10, 4'b1001, 32'd1, 1'b0, 10'd962, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'hABCD, 32'h0, 2'b10, 4'b1000, 32'hABCD, 1'b0, 10'd0, 10'd0));
`else
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'd1, 32'h100, 2'b10, 4'b1111, 32'd0, 1'b1, 10'd256, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'h80000000, 32'h7C2, 2'b10, 4'b1111, 32'd0, 1'b1, 10'd962, 10'd0));
        rows.push_back(mk(0, 1, 0, 10'd0, 32'd0, 32'hABCD, 32'h0, 2'b10, 4'b1111, 32'd0, 1'b1, 10'd0, 10'd0));
`endif
        run_rows("shift", rows);
    endtask

    task automatic test_back_to_back();
        logic [5:0] functs[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02};
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            stim_t t;
            t.rst = 1'b0; t.en = 1'b1; t.fl = ($urandom_range(7) == 0);
            t.pc = 10'($urandom); t.a = $urandom; t.b = ($urandom_range(3) == 0) ? t.a : $urandom;
            t.s = $urandom; t.op = 2'($urandom);
            if ($urandom_range(3) != 0) t.s[5:0] = functs[$urandom_range(7)];
            t.opx = 4'b0;
            t.e = t.fl ? exp_t'(0) : model(t.op, t.a, t.b, t.s, t.pc);
            apply(t);
            e = q.pop_front();
            tests++;
            if ({aluResult, zero, outPC, outCurrentPC} !== e) begin
                fails++;
                $display("FAIL back_to_back[%0d]: op=%b s=%h a=%h b=%h got r=%h z=%b pc=%0d cur=%0d expected r=%h z=%b pc=%0d cur=%0d",
                         i, t.op, t.s, t.a, t.b, aluResult, zero, outPC, outCurrentPC, e.r, e.z, e.pc, e.cur);
            end
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_rtype();
        test_add_wrap();
        test_branch();
        test_stall_flush();
        test_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
